resp_sender: RTL and testbench
==============================

RESP_SENDER -- requirements
Module: resp_sender

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 match  input  1  one-cycle pulse; a reply request is present.
REQ-005 match_code  input  8  ASCII result code, sampled on the match cycle.
REQ-006 tx_ready  input  1  UART transmitter can accept a byte.
REQ-007 tx_valid  output  1  tx_data holds a byte to send.
REQ-008 tx_data  output  8  reply byte.
REQ-009 busy  output  1  a reply is in progress or pending.
REQ-010 drop  output  1  one-cycle pulse; a request was discarded.

Function
REQ-011 Reply text by code: 0x30 "NONE", 0x31 "START", 0x32 "STOP", 0x33 "HITSZ", any other value "?"; each reply is followed by the terminator (REQ-027/028).
REQ-012 Byte transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
REQ-013 While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold their values.
REQ-014 States: IDLE, TEXT (string bytes), EOL (terminator bytes).
REQ-015 IDLE: tx_valid=0; match at cycle N gives TEXT at N+1 with tx_valid=1 and tx_data = first character.
REQ-016 TEXT: on each transfer, the index advances; transfer of the last character moves to EOL on the next cycle.
REQ-017 EOL: on each transfer, the terminator index advances; transfer of the last terminator byte ends the reply.
REQ-018 Reply end with pending empty: go to IDLE next cycle, with tx_valid=0.
REQ-019 Reply end with pending full: the next cycle is TEXT with the first character of the pending code, tx_valid stays 1, and pending clears.
REQ-020 Pending: one-deep register (code + valid).
  - match while not IDLE and pending empty latches match_code.
  - This includes a match on the final-transfer cycle.
REQ-021 match while not IDLE and pending full: the request is discarded and drop=1 on the next cycle; the pending content is unchanged.
REQ-022 busy=1 whenever the state is not IDLE or pending is valid; busy=0 otherwise.
REQ-023 Character index width: 3 bits; max string length 5; there is no wrap past the string end.
REQ-024 tx_ready high in IDLE has no effect.

Reset
REQ-025 rst forces:
  - state=IDLE
  - tx_valid=0, tx_data=0x00, busy=0, drop=0
  - pending cleared, indices cleared
REQ-026 rst mid-reply aborts the reply at once; no partial resume after release.

Configuration
REQ-027 RESP_CRLF_EN defined: the terminator is 0x0D then 0x0A (2 bytes).
REQ-028 RESP_CRLF_EN undefined: the terminator is 0x0A only (1 byte); EOL lasts one transfer.

Verification
REQ-029 tx_ready=1 always, match code 0x31 at cycle 10.
  - RESP_CRLF_EN: tx_data 'S','T','A','R','T',0x0D,0x0A on cycles 11-17.
  - Then tx_valid=0 and busy=0 at cycle 18.
REQ-030 match code 0x32 with tx_ready low for 3 cycles on the 'O' byte.
  - tx_data holds 0x4F with tx_valid=1 across the stall.
  - Output stream "STOP"+terminator is complete, with no duplicated byte.
REQ-031 match code 0x33, then match code 0x30 during the reply.
  - "HITSZ"+terminator is followed immediately by "NONE"+terminator; tx_valid does not drop between the replies.
REQ-032 Three matches (0x31, 0x32, 0x33) within one reply.
  - The third request gives drop=1 for one cycle.
  - Output is "START" then "STOP" only.
REQ-033 match code 0x41 -> "?"+terminator.
REQ-034 rst asserted during 'I' of "HITSZ".
  - Outputs go to reset values asynchronously.
  - After release, tx_valid stays 0 until the next match.

Source files
------------

// File: rtl/resp_sender.sv
// Reply sender: streams a short ASCII reply plus line terminator per request.
// Ports: clk, rst (async, active-high); match/match_code request in;
//   tx_valid/tx_ready/tx_data byte stream out; busy and drop status.
// Build option: RESP_CRLF_EN selects a CR+LF terminator instead of LF only.
module resp_sender (
    input  logic       clk,
    input  logic       rst,
    input  logic       match,
    input  logic [7:0] match_code,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       drop
);

    typedef enum logic [1:0] {
        IDLE,
        TEXT,
        EOL
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] code_q, code_d;
    logic [2:0] idx_q, idx_d;
    logic       pend_v_q, pend_v_d;
    logic [7:0] pend_code_q, pend_code_d;
    logic       drop_q, drop_d;
    logic       xfer;
    logic       last_char;
    logic       eol_last;
    logic [7:0] eol_byte;

    // Reply text left-aligned in 40 bits, NUL padded.
    function automatic logic [39:0] str_of(input logic [7:0] c);
        case (c)
            8'h30:   str_of = {"NONE", 8'h00};
            8'h31:   str_of = "START";
            8'h32:   str_of = {"STOP", 8'h00};
            8'h33:   str_of = "HITSZ";
            default: str_of = {"?", 32'h0};
        endcase
    endfunction

    function automatic logic [2:0] len_of(input logic [7:0] c);
        case (c)
            8'h30:   len_of = 3'd4;
            8'h31:   len_of = 3'd5;
            8'h32:   len_of = 3'd4;
            8'h33:   len_of = 3'd5;
            default: len_of = 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] char_of(input logic [7:0] c,
                                           input logic [2:0] i);
        logic [39:0] s;
        s = str_of(c) << {i, 3'b000};
        char_of = s[39:32];
    endfunction

`ifdef RESP_CRLF_EN
    logic eol_q, eol_d;
    assign eol_last = eol_q;
    assign eol_byte = eol_q ? 8'h0A : 8'h0D;
`else
    assign eol_last = 1'b1;
    assign eol_byte = 8'h0A;
`endif

    assign tx_valid  = (state_q != IDLE);
    assign busy      = tx_valid | pend_v_q;
    assign drop      = drop_q;
    assign xfer      = tx_valid & tx_ready;
    assign last_char = (idx_q == len_of(code_q) - 3'd1);

    always_comb begin
        tx_data = 8'h00;
        if (state_q == TEXT) begin
            tx_data = char_of(code_q, idx_q);
        end else if (state_q == EOL) begin
            tx_data = eol_byte;
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        idx_d       = idx_q;
        pend_v_d    = pend_v_q;
        pend_code_d = pend_code_q;
        drop_d      = 1'b0;
`ifdef RESP_CRLF_EN
        eol_d       = eol_q;
`endif

        if (state_q != IDLE && match) begin
            if (pend_v_q) begin
                drop_d = 1'b1;
            end else begin
                pend_v_d    = 1'b1;
                pend_code_d = match_code;
            end
        end

        case (state_q)
            IDLE: begin
                if (match) begin
                    state_d = TEXT;
                    code_d  = match_code;
                    idx_d   = 3'd0;
                end else if (pend_v_q) begin
                    state_d  = TEXT;
                    code_d   = pend_code_q;
                    idx_d    = 3'd0;
                    pend_v_d = 1'b0;
                end
            end
            TEXT: begin
                if (xfer) begin
                    if (last_char) begin
                        state_d = EOL;
                        idx_d   = 3'd0;
`ifdef RESP_CRLF_EN
                        eol_d   = 1'b0;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            EOL: begin
                if (xfer) begin
                    if (eol_last) begin
                        // A request latched this same cycle counts as pending,
                        // so back-to-back replies never gap.
                        if (pend_v_d) begin
                            state_d  = TEXT;
                            code_d   = pend_code_d;
                            idx_d    = 3'd0;
                            pend_v_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
`ifdef RESP_CRLF_EN
                        eol_d = 1'b0;
                    end else begin
                        eol_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= 8'h00;
            idx_q       <= 3'd0;
            pend_v_q    <= 1'b0;
            pend_code_q <= 8'h00;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            idx_q       <= idx_d;
            pend_v_q    <= pend_v_d;
            pend_code_q <= pend_code_d;
            drop_q      <= drop_d;
        end
    end

`ifdef RESP_CRLF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eol_q <= 1'b0;
        end else begin
            eol_q <= eol_d;
        end
    end
`endif

endmodule

// File: tb/tb_resp_sender.sv
// Randomized + directed bench for resp_sender against a byte-queue model.
// Checks every output each cycle; honours RESP_CRLF_EN like the design.
module tb_resp_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       match;
    logic [7:0] match_code;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       drop;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] cur[$];
    bit         pendv;
    logic [7:0] pcode;
    bit         drop_e;

    resp_sender dut (
        .clk        (clk),
        .rst        (rst),
        .match      (match),
        .match_code (match_code),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic string text_of(input logic [7:0] c);
        case (c)
            8'h30:   return "NONE";
            8'h31:   return "START";
            8'h32:   return "STOP";
            8'h33:   return "HITSZ";
            default: return "?";
        endcase
    endfunction

    task automatic load(input logic [7:0] c);
        string s;
        s = text_of(c);
        cur.delete();
        for (int i = 0; i < s.len(); i++) cur.push_back(s[i]);
`ifdef RESP_CRLF_EN
        cur.push_back(8'h0D);
`endif
        cur.push_back(8'h0A);
    endtask

    task automatic model_reset();
        cur.delete();
        pendv  = 0;
        pcode  = 8'h00;
        drop_e = 0;
    endtask

    // Advance the model by one clock using the inputs being applied.
    task automatic model_step(input bit m, input logic [7:0] mc,
                              input bit rdy);
        bit dn;
        dn = 0;
        if (cur.size() == 0) begin
            if (m) load(mc);
        end else begin
            if (m) begin
                if (pendv) dn = 1;
                else begin
                    pendv = 1;
                    pcode = mc;
                end
            end
            if (rdy) begin
                void'(cur.pop_front());
                if (cur.size() == 0 && pendv) begin
                    load(pcode);
                    pendv = 0;
                end
            end
        end
        drop_e = dn;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] ed;
        ed = (cur.size() != 0) ? cur[0] : 8'h00;
        chk({tag, ".valid"}, 32'(tx_valid), 32'(cur.size() != 0));
        chk({tag, ".data"},  32'(tx_data),  32'(ed));
        chk({tag, ".busy"},  32'(busy),     32'(cur.size() != 0 || pendv));
        chk({tag, ".drop"},  32'(drop),     32'(drop_e));
    endtask

    // Called at a negedge: apply inputs, wait one cycle, compare.
    task automatic cyc(input string tag, input bit m,
                       input logic [7:0] mc, input bit rdy);
        match      = m;
        match_code = mc;
        tx_ready   = rdy;
        model_step(m, mc, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_n(input string tag, input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(tag, 0, 8'h00, rdy);
    endtask

    initial begin
        rst        = 1'b1;
        match      = 1'b0;
        match_code = 8'h00;
        tx_ready   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // START with ready always high
        idle_n("pre", 9, 1);
        cyc("start", 1, 8'h31, 1);
        idle_n("start", 10, 1);

        // STOP stalled three cycles on 'O'
        cyc("stop", 1, 8'h32, 1);
        idle_n("stop", 2, 1);
        chk("stop.o_byte", 32'(tx_data), 32'h4F);
        idle_n("stall", 3, 0);
        idle_n("stop", 8, 1);

        // HITSZ then NONE queued mid-reply
        cyc("hit", 1, 8'h33, 1);
        cyc("hit", 0, 8'h00, 1);
        cyc("hit", 1, 8'h30, 1);
        idle_n("hit", 14, 1);

        // three requests within one reply: third dropped
        cyc("tri", 1, 8'h31, 1);
        cyc("tri", 1, 8'h32, 1);
        cyc("tri", 1, 8'h33, 1);
        chk("tri.drop", 32'(drop), 32'd1);
        idle_n("tri", 18, 1);

        // unknown code
        cyc("unk", 1, 8'h41, 1);
        idle_n("unk", 5, 1);

        // asynchronous reset while 'I' of HITSZ is presented
        cyc("rst", 1, 8'h33, 1);
        cyc("rst", 0, 8'h00, 1);
        chk("rst.i_byte", 32'(tx_data), 32'h49);
        #2 rst = 1'b1;
        #1;
        chk("rst.valid", 32'(tx_valid), 32'd0);
        chk("rst.data",  32'(tx_data),  32'd0);
        chk("rst.busy",  32'(busy),     32'd0);
        chk("rst.drop",  32'(drop),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_n("post_rst", 8, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit         m;
            bit         r;
            logic [7:0] c;
            m = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) c = 8'($urandom);
            else c = 8'h30 + 8'($urandom_range(0, 3));
            cyc("rand", m, c, r);
        end
        idle_n("drain", 30, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
